// File: rtl/bram_bank_arbiter_pkg.sv
// Shared definitions for the BRAM bank scheduling blocks: requester IDs and the
// address-ownership test used by every bank instance.
package bram_sched_pkg;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // Inclusive on both ends; callers zero-extend to 64 bits so any address width fits.
  function automatic logic in_range(input logic [63:0] addr,
                                    input logic [63:0] lo,
                                    input logic [63:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/bram_bank_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: ptr names the port that wins a tie, and the
// pointer moves to the loser after any grant.
module rr_arb2
  import bram_sched_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       ptr_next
);

  always_comb begin
    gnt      = 2'b00;
    ptr_next = ptr;
    if (req == 2'b11) gnt = (ptr == PORT_A) ? 2'b01 : 2'b10;
    else              gnt = req;
    if (gnt[0])      ptr_next = PORT_B;
    else if (gnt[1]) ptr_next = PORT_A;
  end

endmodule

// File: rtl/bram_bank_arbiter.sv
// One BRAM bank shared by requesters A and B: round-robin grant, registered
// memory port, read-data routing back to the issuing port, contention counter.
module bram_bank_arbiter
  import bram_sched_pkg::*;
#(
  parameter int ADDR_WIDTH     = 13,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int LOWER_ADDR     = 0,
  parameter int UPPER_ADDR     = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_a,
  input  logic [ADDR_WIDTH-1:0]     addr_a,
  input  logic [DATA_WIDTH-1:0]     wdata_a,
  input  logic                      we_a,
  input  logic                      req_b,
  input  logic [ADDR_WIDTH-1:0]     addr_b,
  input  logic [DATA_WIDTH-1:0]     wdata_b,
  input  logic                      we_b,
  output logic                      gnt_a,
  output logic                      gnt_b,
  output logic                      rvalid_a,
  output logic                      rvalid_b,
  output logic [DATA_WIDTH-1:0]     rdata_a,
  output logic [DATA_WIDTH-1:0]     rdata_b,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      conflict,
  output logic [CNT_WIDTH-1:0]      conflict_cnt
);

  typedef struct packed {
    logic                      we;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]     wdata;
  } issue_t;

  logic       in_a, in_b, both;
  logic [1:0] arb_req, arb_gnt;
  logic       ptr, ptr_next;
  logic       any_gnt, win;
  issue_t     iss_a, iss_b, iss;
  logic [2:1] vld_pipe;
  logic [2:1] own_pipe;

  assign in_a    = in_range(64'(addr_a), 64'(LOWER_ADDR), 64'(UPPER_ADDR));
  assign in_b    = in_range(64'(addr_b), 64'(LOWER_ADDR), 64'(UPPER_ADDR));
  assign arb_req = {req_b & in_b, req_a & in_a};
  assign both    = &arb_req;

  rr_arb2 u_arb (
    .req      (arb_req),
    .ptr      (ptr),
    .gnt      (arb_gnt),
    .ptr_next (ptr_next)
  );

  // Grants are combinational but must read as zero while reset is held.
  assign gnt_a   = arb_gnt[0] & rst_n;
  assign gnt_b   = arb_gnt[1] & rst_n;
  assign any_gnt = gnt_a | gnt_b;
  assign win     = gnt_b ? PORT_B : PORT_A;

  // Truncated subtraction in the local width equals the low bits of the full difference.
  assign iss_a = '{we: we_a, wdata: wdata_a,
                   addr: MEM_ADDR_WIDTH'(addr_a) - MEM_ADDR_WIDTH'(LOWER_ADDR)};
  assign iss_b = '{we: we_b, wdata: wdata_b,
                   addr: MEM_ADDR_WIDTH'(addr_b) - MEM_ADDR_WIDTH'(LOWER_ADDR)};
  assign iss   = (win == PORT_B) ? iss_b : iss_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= PORT_A;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (any_gnt) begin
        ptr       <= ptr_next;
        mem_en    <= 1'b1;
        mem_we    <= iss.we;
        mem_addr  <= iss.addr;
        mem_wdata <= iss.wdata;
      end else begin
        mem_en <= 1'b0;
        mem_we <= 1'b0;
      end
    end
  end

  // Read tracking: stage 1 aligns with the memory issue, stage 2 with returned data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      own_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], any_gnt & ~iss.we};
      own_pipe <= {own_pipe[1], win};
    end
  end

  assign rvalid_a = vld_pipe[2] & (own_pipe[2] == PORT_A);
  assign rvalid_b = vld_pipe[2] & (own_pipe[2] == PORT_B);
  assign rdata_a  = mem_rdata;
  assign rdata_b  = mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict     <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      conflict <= both;
      if (both && (conflict_cnt != '1)) conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bram_bank_arbiter.sv
// Directed bench: three bank instances (bank 0..4, bank 8..12, bank 0..4 with a
// 3-bit counter) share the requester inputs; a small BRAM model feeds bank 0.
module tb_bram_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_a, req_b, we_a, we_b;
  logic [12:0] addr_a, addr_b;
  logic [31:0] wdata_a, wdata_b;
  logic [31:0] zero_rdata;

  logic        gnt_a, gnt_b, rvalid_a, rvalid_b, mem_en, mem_we, conflict;
  logic [31:0] rdata_a, rdata_b, mem_wdata;
  logic [31:0] mem_rdata;
  logic [9:0]  mem_addr;
  logic [15:0] conflict_cnt;

  logic        d1_gnt_a, d1_gnt_b, d1_rvalid_a, d1_rvalid_b, d1_mem_en, d1_mem_we, d1_conflict;
  logic [31:0] d1_rdata_a, d1_rdata_b, d1_mem_wdata;
  logic [9:0]  d1_mem_addr;
  logic [15:0] d1_conflict_cnt;

  logic        d2_gnt_a, d2_gnt_b, d2_rvalid_a, d2_rvalid_b, d2_mem_en, d2_mem_we, d2_conflict;
  logic [31:0] d2_rdata_a, d2_rdata_b, d2_mem_wdata;
  logic [9:0]  d2_mem_addr;
  logic [2:0]  d2_conflict_cnt;

  logic [31:0] mem [0:15];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bram_bank_arbiter #(.LOWER_ADDR(0), .UPPER_ADDR(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .addr_a(addr_a), .wdata_a(wdata_a), .we_a(we_a),
    .req_b(req_b), .addr_b(addr_b), .wdata_b(wdata_b), .we_b(we_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .conflict(conflict), .conflict_cnt(conflict_cnt));

  bram_bank_arbiter #(.LOWER_ADDR(8), .UPPER_ADDR(12), .CNT_WIDTH(16)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .addr_a(addr_a), .wdata_a(wdata_a), .we_a(we_a),
    .req_b(req_b), .addr_b(addr_b), .wdata_b(wdata_b), .we_b(we_b),
    .gnt_a(d1_gnt_a), .gnt_b(d1_gnt_b), .rvalid_a(d1_rvalid_a), .rvalid_b(d1_rvalid_b),
    .rdata_a(d1_rdata_a), .rdata_b(d1_rdata_b), .mem_en(d1_mem_en), .mem_we(d1_mem_we),
    .mem_addr(d1_mem_addr), .mem_wdata(d1_mem_wdata), .mem_rdata(zero_rdata),
    .conflict(d1_conflict), .conflict_cnt(d1_conflict_cnt));

  bram_bank_arbiter #(.LOWER_ADDR(0), .UPPER_ADDR(4), .CNT_WIDTH(3)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .addr_a(addr_a), .wdata_a(wdata_a), .we_a(we_a),
    .req_b(req_b), .addr_b(addr_b), .wdata_b(wdata_b), .we_b(we_b),
    .gnt_a(d2_gnt_a), .gnt_b(d2_gnt_b), .rvalid_a(d2_rvalid_a), .rvalid_b(d2_rvalid_b),
    .rdata_a(d2_rdata_a), .rdata_b(d2_rdata_b), .mem_en(d2_mem_en), .mem_we(d2_mem_we),
    .mem_addr(d2_mem_addr), .mem_wdata(d2_mem_wdata), .mem_rdata(zero_rdata),
    .conflict(d2_conflict), .conflict_cnt(d2_conflict_cnt));

  // BRAM model: a write lands at the issuing edge, so the next issued read sees it.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;
      else        mem_rdata          <= mem[mem_addr[3:0]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_a = 0; req_b = 0; we_a = 0; we_b = 0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h1000 + i;
    mem_rdata = '0;
    zero_rdata = '0;
    addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
    idle();
    rst_n = 0;
    req_a = 1; addr_a = 13'd1;
    #3;
    chk("rst_gnt_a", gnt_a, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_rvalid", {rvalid_a, rvalid_b}, 2'b00);
    chk("rst_cnt", conflict_cnt, 16'd0);
    idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // single read from A
    req_a = 1; addr_a = 13'd3; we_a = 0;
    #1;
    chk("t1_gnt_a", gnt_a, 1'b1);
    chk("t1_gnt_b", gnt_b, 1'b0);
    tick(); idle();
    chk("t1_mem_en", mem_en, 1'b1);
    chk("t1_mem_addr", mem_addr, 10'd3);
    chk("t1_mem_we", mem_we, 1'b0);
    chk("t1_rvalid_early", rvalid_a, 1'b0);
    tick();
    chk("t1_rvalid_a", rvalid_a, 1'b1);
    chk("t1_rdata_a", rdata_a, 32'h1003);
    chk("t1_rvalid_b", rvalid_b, 1'b0);
    tick();
    chk("t1_rvalid_end", rvalid_a, 1'b0);
    chk("t1_mem_en_idle", mem_en, 1'b0);

    // contention from a fresh reset: alternate A,B,A,B
    rst_n = 0; #2; rst_n = 1;
    req_a = 1; addr_a = 13'd1; req_b = 1; addr_b = 13'd2;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_gnt_a", gnt_a, (k % 2 == 0));
      chk("t2_gnt_b", gnt_b, (k % 2 == 1));
      tick();
      chk("t2_conflict", conflict, 1'b1);
      chk("t2_mem_addr", mem_addr, (k % 2 == 0) ? 10'd1 : 10'd2);
    end
    chk("t2_cnt4", conflict_cnt, 16'd4);
    idle();
    tick();
    chk("t2_conflict_off", conflict, 1'b0);
    chk("t2_cnt_hold", conflict_cnt, 16'd4);
    chk("t2_rvalid_b", rvalid_b, 1'b1);
    chk("t2_rdata_b", rdata_b, 32'h1002);
    tick(); tick();

    // range bounds on the 8..12 bank
    req_b = 1; addr_b = 13'd7;
    #1 chk("t3_below", d1_gnt_b, 1'b0);
    addr_b = 13'd13;
    #1 chk("t3_above", d1_gnt_b, 1'b0);
    chk("t3_bank0_oor", gnt_b, 1'b0);
    addr_b = 13'd8;
    #1 chk("t3_lo_gnt", d1_gnt_b, 1'b1);
    tick();
    chk("t3_lo_addr", d1_mem_addr, 10'd0);
    chk("t3_lo_en", d1_mem_en, 1'b1);
    addr_b = 13'd12;
    #1 chk("t3_hi_gnt", d1_gnt_b, 1'b1);
    tick(); idle();
    chk("t3_hi_addr", d1_mem_addr, 10'd4);
    tick(); tick();

    // write then read the same address from A
    req_a = 1; we_a = 1; addr_a = 13'd2; wdata_a = 32'hDEADBEEF;
    #1 chk("t4_wr_gnt", gnt_a, 1'b1);
    tick();
    we_a = 0;
    chk("t4_mem_we", mem_we, 1'b1);
    chk("t4_mem_wdata", mem_wdata, 32'hDEADBEEF);
    #1 chk("t4_rd_gnt", gnt_a, 1'b1);
    tick(); idle();
    chk("t4_we_once", mem_we, 1'b0);
    chk("t4_rd_en", mem_en, 1'b1);
    chk("t4_no_wr_rvalid", rvalid_a, 1'b0);
    tick();
    chk("t4_rvalid", rvalid_a, 1'b1);
    chk("t4_rdata", rdata_a, 32'hDEADBEEF);
    tick();
    chk("t4_rvalid_end", rvalid_a, 1'b0);

    // reset in the middle of a read
    req_a = 1; addr_a = 13'd3; we_a = 0;
    tick(); idle();
    chk("t5_issue", mem_en, 1'b1);
    rst_n = 0;
    req_a = 1; addr_a = 13'd0;
    #1;
    chk("t5_en_rst", mem_en, 1'b0);
    chk("t5_addr_rst", mem_addr, 10'd0);
    chk("t5_gnt_rst", gnt_a, 1'b0);
    idle();
    #2 rst_n = 1;
    tick();
    chk("t5_no_rvalid1", {rvalid_a, rvalid_b}, 2'b00);
    tick();
    chk("t5_no_rvalid2", {rvalid_a, rvalid_b}, 2'b00);
    req_a = 1; addr_a = 13'd1; req_b = 1; addr_b = 13'd2;
    #1;
    chk("t5_ptr_a", {gnt_b, gnt_a}, 2'b01);
    idle();

    // 3-bit counter saturation
    req_a = 1; addr_a = 13'd1; req_b = 1; addr_b = 13'd2;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 6) chk("t6_cnt6", d2_conflict_cnt, 3'd6);
    end
    idle();
    chk("t6_sat", d2_conflict_cnt, 3'd7);
    chk("t6_wide_cnt", conflict_cnt, 16'd10);
    tick();
    chk("t6_sat_hold", d2_conflict_cnt, 3'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
